// File: rtl/port_alloc_pkg.sv
// Shared port/flit definitions and allocation helpers for the bufferless router port allocator.
`ifndef PORT_ALLOC_GLOBAL_DEFS
`define PORT_ALLOC_GLOBAL_DEFS
`define NUM_PORT   5
`define FLIT_WIDTH 16
`define PORT_N     0
`define PORT_E     1
`define PORT_S     2
`define PORT_W     3
`define PORT_LOCAL 4
`endif

package port_alloc_pkg;

  localparam int NUM_PORT   = `NUM_PORT;
  localparam int NUM_NET    = `PORT_LOCAL;
  localparam int PORT_LOCAL = `PORT_LOCAL;

  typedef logic [NUM_PORT-1:0] port_vec_t;
  typedef logic [2:0]          port_idx_t;
  typedef logic [1:0]          in_idx_t;

  // Network ports only: the local ejection port is excluded from deflection targets.
  localparam port_vec_t NET_MASK = ~(port_vec_t'(1) << PORT_LOCAL);

  function automatic port_idx_t lowest_index(input port_vec_t vec);
    lowest_index = '0;
    for (int i = NUM_PORT - 1; i >= 0; i--) begin
      if (vec[i]) lowest_index = port_idx_t'(i);
    end
  endfunction

endpackage

// File: rtl/port_alloc_if.sv
// Flit-level bus between the input stage and the port allocator.
interface port_alloc_if #(
  parameter int FLIT_WIDTH = `FLIT_WIDTH,
  parameter int AGE_WIDTH  = 8
);
  logic [3:0]                     in_valid;
  logic [4*FLIT_WIDTH-1:0]        in_flit;
  logic [4*`NUM_PORT-1:0]         in_ppv;
  logic [4*AGE_WIDTH-1:0]         in_age;
  logic                           inj_valid;
  logic [FLIT_WIDTH-1:0]          inj_flit;
  logic [`NUM_PORT-1:0]           inj_ppv;
  logic                           inj_ack;
  logic [`NUM_PORT-1:0]           out_valid;
  logic [`NUM_PORT*FLIT_WIDTH-1:0] out_flit;

  modport master (
    output in_valid, in_flit, in_ppv, in_age, inj_valid, inj_flit, inj_ppv,
    input  inj_ack, out_valid, out_flit
  );

  modport slave (
    input  in_valid, in_flit, in_ppv, in_age, inj_valid, inj_flit, inj_ppv,
    output inj_ack, out_valid, out_flit
  );
endinterface

// File: rtl/port_alloc_rank.sv
// Orders the four network inputs: valid before invalid, older first, lower index on ties.
module port_alloc_rank
  import port_alloc_pkg::*;
#(
  parameter int AGE_WIDTH = 8
) (
  input  logic [3:0]             valid,
  input  logic [4*AGE_WIDTH-1:0] age,
  output in_idx_t [3:0]          order
);

  function automatic logic beats(input int j, input int i,
                                 input logic [3:0] v,
                                 input logic [4*AGE_WIDTH-1:0] a);
    logic [AGE_WIDTH-1:0] age_j;
    logic [AGE_WIDTH-1:0] age_i;
    age_j = a[j*AGE_WIDTH +: AGE_WIDTH];
    age_i = a[i*AGE_WIDTH +: AGE_WIDTH];
    if (v[j] != v[i]) beats = v[j];
    else              beats = (age_j > age_i) || ((age_j == age_i) && (j < i));
  endfunction

  // Each input's slot is the number of inputs that beat it, so slots form a permutation.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    order = '0;
    for (int i = 0; i < 4; i++) begin
      in_idx_t rank;
      rank = '0;
      for (int j = 0; j < 4; j++) begin
        if (j != i && beats(j, i, valid, age)) rank = rank + in_idx_t'(1);
      end
      order[rank] = in_idx_t'(i);
    end
  end

endmodule

// File: rtl/port_alloc.sv
// Bufferless deflection port allocator: ranks network flits, assigns ports, registers outputs.
module port_alloc
  import port_alloc_pkg::*;
#(
  parameter int FLIT_WIDTH = `FLIT_WIDTH,
  parameter int AGE_WIDTH  = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  port_alloc_if.slave          bus,
  output logic [CNT_WIDTH-1:0] defl_count
);

  in_idx_t [3:0]                        order;
  port_vec_t                            free;
  port_vec_t                            want;
  port_vec_t                            ppv;
  port_idx_t                            port;
  port_vec_t                            nxt_valid;
  logic [NUM_PORT-1:0][FLIT_WIDTH-1:0]  nxt_flit;
  logic [2:0]                           defl_n;
  logic                                 inj_grant;
  logic [CNT_WIDTH:0]                   cnt_sum;

  port_alloc_rank #(.AGE_WIDTH(AGE_WIDTH)) u_rank (
    .valid (bus.in_valid),
    .age   (bus.in_age),
    .order (order)
  );

  always_comb begin
    free      = '1;
    want      = '0;
    ppv       = '0;
    port      = '0;
    nxt_valid = '0;
    nxt_flit  = '0;
    defl_n    = '0;
    inj_grant = 1'b0;
    // Network flits in priority order; with at most four of them a network port is always left.
    for (int k = 0; k < NUM_NET; k++) begin
      ppv = bus.in_ppv[int'(order[k])*NUM_PORT +: NUM_PORT];
      if (bus.in_valid[order[k]]) begin
        want = ppv & free;
        port = (|want) ? lowest_index(want) : lowest_index(free & NET_MASK);
        if (!ppv[port]) defl_n = defl_n + 3'd1;
        free[port]      = 1'b0;
        nxt_valid[port] = 1'b1;
        nxt_flit[port]  = bus.in_flit[int'(order[k])*FLIT_WIDTH +: FLIT_WIDTH];
      end
    end
    // Injection only fills leftover network ports and never ejects.
    want = bus.inj_ppv & NET_MASK & free;
    if (bus.inj_valid && |(free & NET_MASK)) begin
      inj_grant       = 1'b1;
      port            = (|want) ? lowest_index(want) : lowest_index(free & NET_MASK);
      if (!want[port]) defl_n = defl_n + 3'd1;
      nxt_valid[port] = 1'b1;
      nxt_flit[port]  = bus.inj_flit;
    end
  end

  assign bus.inj_ack = inj_grant && !reset;
  assign cnt_sum     = {1'b0, defl_count} + {{(CNT_WIDTH-2){1'b0}}, defl_n};

  always_ff @(posedge clk) begin
    // NOTE: registered state is written with non-blocking assignments only.
    if (reset) begin
      bus.out_valid <= '0;
      bus.out_flit  <= '0;
      defl_count    <= '0;
    end else begin
      bus.out_valid <= nxt_valid;
      bus.out_flit  <= nxt_flit;
      defl_count    <= cnt_sum[CNT_WIDTH] ? '1 : cnt_sum[CNT_WIDTH-1:0];
    end
  end

endmodule

// File: doc/port_alloc.md
PORT_ALLOC -- requirements
Module: port_alloc

Interface
REQ-001 Parameter FLIT_WIDTH, default `FLIT_WIDTH (global.vh): flit data width in bits.
REQ-002 Parameter AGE_WIDTH, default 8: age field width; larger value = older flit.
REQ-003 Parameter CNT_WIDTH, default 16: deflection counter width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  4  per network input (0=N,1=E,2=S,3=W) flit-present flag.
REQ-007 in_flit  input  4*FLIT_WIDTH  network flits; slice i belongs to input i.
REQ-008 in_ppv  input  4*`NUM_PORT  preferPortVector per input from route computation; bit order N,E,S,W,Local.
REQ-009 in_age  input  4*AGE_WIDTH  age per network input.
REQ-010 inj_valid  input  1  local injection request.
REQ-011 inj_flit  input  FLIT_WIDTH  injected flit.
REQ-012 inj_ppv  input  `NUM_PORT  preferPortVector for injected flit.
REQ-013 inj_ack  output  1  combinational; injected flit accepted this cycle.
REQ-014 out_valid  output  `NUM_PORT  registered per output port valid.
REQ-015 out_flit  output  `NUM_PORT*FLIT_WIDTH  registered output flits, slice p = port p.
REQ-016 defl_count  output  CNT_WIDTH  registered saturating count of deflected flits.

Function
REQ-017 Block SHALL assign every valid network flit exactly one distinct output port each cycle (bufferless: no flit dropped, no flit stalled).
REQ-018 Priority order SHALL be: higher in_age first; on equal age, lower input index first; injected flit last.
REQ-019 In priority order, each flit SHALL take the lowest-index free port set in its ppv; if none is free it SHALL take the lowest-index free network port (0..3) = deflection.
REQ-020 Port 4 (Local) SHALL be granted only to a network flit with ppv bit 4 set; at most one ejection per cycle; losers deflect per REQ-019.
REQ-021 Injected flit SHALL ignore inj_ppv bit 4, never take port 4, and be allocated only after all network flits.
REQ-022 inj_ack SHALL be 1 iff inj_valid=1 and at least one network port remains free after network allocation; when 0, injection requester retries, nothing latched.
REQ-023 Invalid inputs SHALL consume no port regardless of data, ppv or age.
REQ-024 A flit with all-zero ppv SHALL be treated as deflected.
REQ-025 Latency SHALL be exactly one cycle: allocation of cycle N appears on out_valid/out_flit after edge N+1; unassigned ports out_valid=0, out_flit=0.
REQ-026 defl_count SHALL add the number of flits (0..5, injected included) assigned a port outside their ppv each cycle, saturating at all-ones.
REQ-027 Flit data SHALL pass unmodified.

Reset
REQ-028 While reset=1 at an edge: out_valid=0, out_flit=0, defl_count=0; inputs that cycle are discarded.
REQ-029 inj_ack SHALL be 0 while reset=1.
REQ-030 Reset mid-traffic SHALL drop in-register flits; first post-reset outputs reflect inputs of first cycle with reset=0.

Structure
REQ-031 `NUM_PORT, `FLIT_WIDTH, port index defines (N/E/S/W/LOCAL) SHALL live in shared global.vh; no local redefinition.
REQ-032 Priority ranking (age compare, index tiebreak, producing a 4-entry order) SHALL be sub-module port_alloc_rank; allocation and registers in port_alloc.

Verification
REQ-033 Single flit in_valid=0001, ppv=00010 (E) -> next cycle out_valid=00010, out_flit[1]=in_flit[0], defl_count=0.
REQ-034 Inputs 0 (age 5) and 2 (age 9) both ppv=00001 (N) -> port 0 gets input 2, input 0 deflects to port 1, defl_count=1.
REQ-035 Equal age 3 on inputs 1 and 3, both ppv=10000 (Local) -> port 4 gets input 1, input 3 deflects to port 0.
REQ-036 All 4 network inputs valid, none local, inj_valid=1 -> inj_ack=0, out_valid=01111; then 3 network inputs valid -> inj_ack=1, injected flit on remaining network port.
REQ-037 Force defl_count to all-ones minus 1 via 2 deflections then 3 deflections/cycle -> saturates at 0xFFFF, no wrap.
REQ-038 Reset asserted with out_valid=11111 -> after edge out_valid=0, defl_count=0, inj_ack=0 during reset.
